// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// data-first with a starvation guard for fetch. Optional counters: MEM_PORT_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
`ifdef MEM_PORT_ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts,
    output logic [15:0]   stat_starve_grants
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            dm_valid_q, dm_valid_d;
    logic [3:0]      starve_q, starve_d;
    logic            drop_q, drop_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            starve_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_valid_q  <= dm_valid_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_valid_d  = 1'b0;
        starve_d    = starve_q;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                if (if_req && (starve_q == STARVE_LIM || !dm_req)) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                    drop_d      = 1'b0;
                end else if (dm_req) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    // Only data grants that keep a waiting fetch out count toward starvation.
                    if (if_req && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    // A flush seen earlier or in the completing cycle discards the result.
                    if (!drop_q && !if_flush) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                    drop_d    = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (if_flush) begin
                    drop_d = 1'b1;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

`ifdef MEM_PORT_ARB_STATS_EN
    logic [15:0] conflicts_q, conflicts_d;
    logic [15:0] starve_grants_q, starve_grants_d;
    logic        conflict_now;
    logic        forced_now;

    assign conflict_now = if_req & dm_req & ~if_valid_q & ~dm_valid_q;
    assign forced_now   = (state_q == IDLE) & if_req & (starve_q == STARVE_LIM);

    always_comb begin
        conflicts_d     = conflicts_q;
        starve_grants_d = starve_grants_q;
        if (conflict_now && conflicts_q != 16'hFFFF) begin
            conflicts_d = conflicts_q + 16'd1;
        end
        if (forced_now && starve_grants_q != 16'hFFFF) begin
            starve_grants_d = starve_grants_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflicts_q     <= '0;
            starve_grants_q <= '0;
        end else begin
            conflicts_q     <= conflicts_d;
            starve_grants_q <= starve_grants_d;
        end
    end

    assign stat_conflicts     = conflicts_q;
    assign stat_starve_grants = starve_grants_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Sits between the pipeline stages and the memory macro.
- Data accesses win by default; a starvation guard forces a fetch grant after STARVE_MAX consecutive data grants.
- Drives stall outputs so the pipeline controller can freeze the PC and the IF/ID register.

Parameters:
- AW, 16, address width (bits).
- DW, 16, data width (bits).
- STARVE_MAX, 3, consecutive data grants allowed while fetch waits (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; level, held until if_valid.
- if_addr  in  AW  fetch address; stable while if_req.
- if_flush  in  1  branch flush; drop any outstanding fetch result.
- if_rdata  out  DW  fetched instruction, registered.
- if_valid  out  1  one-cycle pulse, if_rdata valid.
- dm_req  in  1  data request; level, held until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  read data, registered.
- dm_valid  out  1  one-cycle pulse, data access complete (read or write).
- stall_if  out  1  if_req & ~if_valid.
- stall_mem  out  1  dm_req & ~dm_valid.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset: clk/rst only; rst is synchronous active-high.
  - State IDLE; all outputs 0; starve_cnt = 0; drop flag = 0.
- FSM states: IDLE, FETCH, DATA.
- IDLE arbitration, evaluated on the edge:
  - If if_req and starve_cnt == STARVE_MAX: go to FETCH.
  - Else if dm_req: go to DATA.
  - Else if if_req: go to FETCH.
  - Otherwise stay in IDLE.
- On a grant, register mem_req=1 plus mem_addr, mem_we and mem_wdata from the winner.
  - For fetch grants, mem_we = 0 and mem_wdata = 0.
- FETCH/DATA:
  - Hold mem_* stable until mem_ready is sampled high.
  - On that edge: capture mem_rdata, pulse the matching valid, clear mem_req, return to IDLE.
- Latency:
  - Request seen in IDLE at edge N.
  - mem_req high after edge N.
  - With mem_ready in the first cycle, valid is high in cycle N+2.
  - One IDLE bubble between back-to-back accesses.
- starve_cnt:
  - +1 (saturating) on each data grant made while if_req = 1.
  - Cleared on any fetch grant.
  - Unchanged on a data grant with if_req = 0.
- Writes: dm_valid pulses on completion; dm_rdata keeps its previous value.
- Flush:
  - if_flush while in FETCH sets drop.
  - On completion with drop set: if_valid is not pulsed, if_rdata is unchanged, drop is cleared.
  - if_flush in the same cycle as the completing mem_ready also suppresses if_valid.
  - if_flush in IDLE or DATA has no effect; the requester is responsible for deasserting if_req.
- Requester drops req mid-access: the access still completes, and the valid pulse is still emitted.
- mem_ready while in IDLE: ignored.
- rst mid-access: next state is IDLE and mem_req = 0 after the edge; the memory must tolerate the abandoned access.
- Simultaneous if_req & dm_req with starve_cnt < STARVE_MAX: data wins.

Optional Feature:
- Macro: MEM_PORT_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_conflicts (16b): cycles with if_req & dm_req both high and neither valid.
  - Adds outputs stat_starve_grants (16b): grants forced by the starvation guard.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single fetch, if_addr=16'h0040, mem_ready in first cycle, mem_rdata=16'h1234 -> mem_req high one cycle, addr 0040, we=0; if_valid at N+2 with if_rdata=1234; stall_if high N..N+1.
- Simultaneous if_req (addr 0010) and dm_req read (addr 0200), starve_cnt=0 -> DATA first, dm_valid, one IDLE bubble, then FETCH, if_valid.
- dm_req held continuously with if_req, STARVE_MAX=3 -> exactly 3 data grants, then a fetch grant, starve_cnt back to 0.
- Data write dm_addr=0300, dm_wdata=ABCD, mem_ready delayed 3 cycles -> mem_we=1, mem_wdata=ABCD held stable 4 cycles; dm_valid one pulse; dm_rdata unchanged.
- Fetch in flight, if_flush pulsed before mem_ready -> no if_valid; if_rdata keeps old value; next fetch returns normally.
- rst asserted in DATA before mem_ready -> after the edge: IDLE, mem_req=0, dm_valid=0, starve_cnt=0.
